// File: rtl/alu_iterative_if.sv
// Operand/result bundle between the ID/EX register and the execute-stage ALU.
// Master drives operands and control, slave returns the registered result.
interface alu_iterative_if #(
    parameter int WIDTH = 32
);
    logic             valid_i;
    logic             ready_o;
    logic [2:0]       ALUCtrl_i;
    logic [WIDTH-1:0] data1_i;
    logic [WIDTH-1:0] data2_i;
    logic             flush_i;
    logic [WIDTH-1:0] data_o;
    logic             zero_o;
    logic             valid_o;
    logic             busy_o;

    modport master (
        output valid_i,
        output ALUCtrl_i,
        output data1_i,
        output data2_i,
        output flush_i,
        input  ready_o,
        input  data_o,
        input  zero_o,
        input  valid_o,
        input  busy_o
    );

    modport slave (
        input  valid_i,
        input  ALUCtrl_i,
        input  data1_i,
        input  data2_i,
        input  flush_i,
        output ready_o,
        output data_o,
        output zero_o,
        output valid_o,
        output busy_o
    );
endinterface

// File: rtl/alu_iterative.sv
// Execute-stage ALU: single-cycle logic/arith/shift ops plus an
// iterative shift-add multiplier that stalls the pipe via ready_o.
module alu_iterative #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic           clk_i,
    input  logic           rst_i,
    alu_iterative_if.slave bus
);
    typedef enum logic {
        IDLE,
        MUL
    } state_t;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_XOR  = 3'b001;
    localparam logic [2:0] OP_SLL  = 3'b010;
    localparam logic [2:0] OP_ADD  = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_ADDI = 3'b110;
    localparam logic [2:0] OP_SRAI = 3'b111;

    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [SHW-1:0]   cnt;

    logic             accept;
    logic             is_mul;
    logic             last_step;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] acc_step;

    assign shamt     = bus.data2_i[SHW-1:0];
    assign is_mul    = (bus.ALUCtrl_i == OP_MUL);
    assign accept    = (state == IDLE) & bus.valid_i & ~bus.flush_i;
    assign last_step = (state == MUL) && (cnt == CNT_LAST);
    assign acc_step  = acc + (mplier[0] ? mcand : '0);

    always_comb begin
        alu_res = '0;
        unique case (bus.ALUCtrl_i)
            OP_AND:  alu_res = bus.data1_i & bus.data2_i;
            OP_XOR:  alu_res = bus.data1_i ^ bus.data2_i;
            OP_SLL:  alu_res = bus.data1_i << shamt;
            OP_ADD:  alu_res = bus.data1_i + bus.data2_i;
            OP_SUB:  alu_res = bus.data1_i - bus.data2_i;
            OP_MUL:  alu_res = '0;
            OP_ADDI: alu_res = bus.data1_i + bus.data2_i;
            OP_SRAI: alu_res = $signed(bus.data1_i) >>> shamt;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept && is_mul) state_nxt = MUL;
            MUL:  if (bus.flush_i || last_step) state_nxt = IDLE;
        endcase
    end

    // ready_o depends on state only, never on valid_i
    always_comb begin
        bus.ready_o = (state == IDLE);
        bus.busy_o  = (state == MUL);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc         <= '0;
            mcand       <= '0;
            mplier      <= '0;
            cnt         <= '0;
            bus.data_o  <= '0;
            bus.zero_o  <= 1'b0;
            bus.valid_o <= 1'b0;
        end else begin
            bus.valid_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept && is_mul) begin
                        acc    <= '0;
                        mcand  <= bus.data1_i;
                        mplier <= bus.data2_i;
                        cnt    <= '0;
                    end else if (accept) begin
                        bus.data_o  <= alu_res;
                        bus.zero_o  <= (alu_res == '0);
                        bus.valid_o <= 1'b1;
                    end
                end
                MUL: begin
                    // a flush abandons the product, even on the last step
                    if (!bus.flush_i) begin
                        acc    <= acc_step;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt + SHW'(1);
                        if (last_step) begin
                            bus.data_o  <= acc_step;
                            bus.zero_o  <= (acc_step == '0);
                            bus.valid_o <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_iterative.sv
// Directed bench for alu_iterative: single-cycle ops, MUL timing,
// flush and reset during MUL.
module tb_alu_iterative;
    logic clk;
    logic rst;
    int   tests;
    int   fails;

    alu_iterative_if #(.WIDTH(32)) bus ();

    alu_iterative #(
        .WIDTH(32),
        .SHW  (5)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        bus.valid_i   = v;
        bus.ALUCtrl_i = op;
        bus.data1_i   = a;
        bus.data2_i   = b;
    endtask

    // bounded wait for valid_o; got=1 if it arrived, n = cycles waited
    task automatic wait_valid(output logic got, output int n);
        got = 1'b0;
        n   = 0;
        while (!got && n < 40) begin
            step();
            n++;
            if (bus.valid_o === 1'b1) got = 1'b1;
        end
    endtask

    initial begin
        logic got;
        int   n;
        int   seen;
        int   bad_busy;

        tests = 0;
        fails = 0;
        rst   = 1'b1;
        bus.flush_i = 1'b0;
        drive(1'b0, 3'b000, 32'h0, 32'h0);
        step();
        step();
        rst = 1'b0;
        chk("rst_data", bus.data_o, 32'h0);
        chk("rst_zero", {31'b0, bus.zero_o}, 32'h0);
        chk("rst_valid", {31'b0, bus.valid_o}, 32'h0);
        chk("rst_ready", {31'b0, bus.ready_o}, 32'h1);
        chk("rst_busy", {31'b0, bus.busy_o}, 32'h0);

        drive(1'b1, 3'b011, 32'd5, 32'd7);
        step();
        drive(1'b0, 3'b000, 32'h0, 32'h0);
        chk("add_valid", {31'b0, bus.valid_o}, 32'h1);
        chk("add_data", bus.data_o, 32'd12);
        chk("add_zero", {31'b0, bus.zero_o}, 32'h0);
        step();
        chk("add_valid_drop", {31'b0, bus.valid_o}, 32'h0);
        chk("add_hold", bus.data_o, 32'd12);

        drive(1'b1, 3'b100, 32'h1234, 32'h1234);
        step();
        drive(1'b1, 3'b001, 32'hF0F0, 32'h0F0F);
        chk("sub_valid", {31'b0, bus.valid_o}, 32'h1);
        chk("sub_data", bus.data_o, 32'h0);
        chk("sub_zero", {31'b0, bus.zero_o}, 32'h1);
        step();
        drive(1'b1, 3'b111, 32'h8000_0000, 32'd4);
        chk("xor_valid", {31'b0, bus.valid_o}, 32'h1);
        chk("xor_data", bus.data_o, 32'hFFFF);
        chk("xor_zero", {31'b0, bus.zero_o}, 32'h0);
        step();
        drive(1'b1, 3'b010, 32'h1, 32'h3F);
        chk("srai_data", bus.data_o, 32'hF800_0000);
        step();
        drive(1'b1, 3'b000, 32'hFF00_FF00, 32'h0FF0_0FF0);
        chk("sll_data", bus.data_o, 32'h8000_0000);
        step();
        drive(1'b1, 3'b110, 32'hFFFF_FFFF, 32'h1);
        chk("and_data", bus.data_o, 32'h0F00_0F00);
        step();
        drive(1'b0, 3'b000, 32'h0, 32'h0);
        chk("addi_wrap", bus.data_o, 32'h0);
        chk("addi_zero", {31'b0, bus.zero_o}, 32'h1);

        // flush in IDLE blocks the accept
        drive(1'b1, 3'b011, 32'd3, 32'd4);
        bus.flush_i = 1'b1;
        step();
        bus.flush_i = 1'b0;
        drive(1'b0, 3'b000, 32'h0, 32'h0);
        chk("idle_flush_valid", {31'b0, bus.valid_o}, 32'h0);
        chk("idle_flush_hold", bus.data_o, 32'h0);

        // MUL with valid_i held high
        drive(1'b1, 3'b101, 32'hFFFF_FFFF, 32'd3);
        step();
        n = 0;
        seen = 0;
        bad_busy = 0;
        while (bus.ready_o === 1'b0 && n < 40) begin
            if (bus.busy_o !== 1'b1) bad_busy++;
            if (bus.valid_o === 1'b1) seen++;
            n++;
            step();
        end
        chk("mul_stall_cycles", n, 32);
        chk("mul_busy_high", bad_busy, 0);
        chk("mul_no_early_valid", seen, 0);
        chk("mul_valid", {31'b0, bus.valid_o}, 32'h1);
        chk("mul_data", bus.data_o, 32'hFFFF_FFFD);
        chk("mul_busy_drop", {31'b0, bus.busy_o}, 32'h0);
        step();
        chk("mul_reaccept", {31'b0, bus.ready_o}, 32'h0);
        chk("mul_pulse_once", {31'b0, bus.valid_o}, 32'h0);
        drive(1'b0, 3'b000, 32'h0, 32'h0);
        bus.flush_i = 1'b1;
        step();
        bus.flush_i = 1'b0;

        // MUL 6*7 flushed on MUL cycle 10
        drive(1'b1, 3'b101, 32'd6, 32'd7);
        step();
        drive(1'b0, 3'b000, 32'h0, 32'h0);
        repeat (9) step();
        chk("flush_in_mul", {31'b0, bus.busy_o}, 32'h1);
        bus.flush_i = 1'b1;
        step();
        bus.flush_i = 1'b0;
        chk("flush_ready", {31'b0, bus.ready_o}, 32'h1);
        chk("flush_valid", {31'b0, bus.valid_o}, 32'h0);
        chk("flush_hold", bus.data_o, 32'hFFFF_FFFD);
        seen = 0;
        repeat (36) begin
            step();
            if (bus.valid_o === 1'b1) seen++;
        end
        chk("flush_no_late_valid", seen, 0);
        drive(1'b1, 3'b011, 32'd1, 32'd1);
        step();
        drive(1'b0, 3'b000, 32'h0, 32'h0);
        chk("post_flush_valid", {31'b0, bus.valid_o}, 32'h1);
        chk("post_flush_add", bus.data_o, 32'd2);

        // MUL 6*7 killed by reset on MUL cycle 5
        drive(1'b1, 3'b101, 32'd6, 32'd7);
        step();
        drive(1'b0, 3'b000, 32'h0, 32'h0);
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst_data", bus.data_o, 32'h0);
        chk("mrst_valid", {31'b0, bus.valid_o}, 32'h0);
        chk("mrst_ready", {31'b0, bus.ready_o}, 32'h1);
        seen = 0;
        repeat (36) begin
            step();
            if (bus.valid_o === 1'b1 || bus.data_o !== 32'h0) seen++;
        end
        chk("mrst_no_stale", seen, 0);

        // complete MUL runs for the product itself
        drive(1'b1, 3'b101, 32'd6, 32'd7);
        step();
        drive(1'b0, 3'b000, 32'h0, 32'h0);
        wait_valid(got, n);
        chk("mul67_done", {31'b0, got}, 32'h1);
        chk("mul67_lat", n, 32);
        chk("mul67_data", bus.data_o, 32'd42);
        chk("mul67_zero", {31'b0, bus.zero_o}, 32'h0);
        drive(1'b1, 3'b101, 32'h1234_5678, 32'h0);
        step();
        drive(1'b0, 3'b000, 32'h0, 32'h0);
        wait_valid(got, n);
        chk("mul0_done", {31'b0, got}, 32'h1);
        chk("mul0_data", bus.data_o, 32'h0);
        chk("mul0_zero", {31'b0, bus.zero_o}, 32'h1);
        drive(1'b1, 3'b101, 32'h0001_0003, 32'h8000_0001);
        step();
        drive(1'b0, 3'b000, 32'h0, 32'h0);
        wait_valid(got, n);
        chk("mulbig_done", {31'b0, got}, 32'h1);
        chk("mulbig_data", bus.data_o, 32'h8001_0003);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
